// File: rtl/board_nibble_unpacker_if.sv
// rtl/board_nibble_unpacker_if.sv - PIO sniff and piece stream bundle for the board nibble unpacker
//
// Groups the sniffed Avalon PIO write qualifiers and the per-square piece
// stream into one interface.
//   chipselect, write_n, address, pio_data : PIO slave qualifiers and out_port word
//   sq_valid, sq_ready                     : piece handshake
//   sq_index, sq_piece                     : square number and piece code
// modport slave  : the unpacker (consumes PIO, produces pieces)
// modport master : the environment (drives PIO, consumes pieces)

interface board_nibble_unpacker_if #(
    parameter int PIECE_W = 4
);
    logic               chipselect;
    logic               write_n;
    logic [1:0]         address;
    logic [31:0]        pio_data;
    logic               sq_ready;
    logic               sq_valid;
    logic [5:0]         sq_index;
    logic [PIECE_W-1:0] sq_piece;

    modport master (
        output chipselect, write_n, address, pio_data, sq_ready,
        input  sq_valid, sq_index, sq_piece
    );

    modport slave (
        input  chipselect, write_n, address, pio_data, sq_ready,
        output sq_valid, sq_index, sq_piece
    );
endinterface

// File: rtl/board_nibble_unpacker.sv
// rtl/board_nibble_unpacker.sv - unpacks 32-bit PIO board words into per-square piece codes
//
// Sniffs PIO writes to address 0, buffers one word in a shift register plus
// one pending word, and streams 32/PIECE_W pieces per word to the board-state
// memory with a valid/ready handshake. sq_index counts squares across words.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus (slave)   : PIO sniff inputs and piece stream (see board_nibble_unpacker_if)
//   restart       : synchronous clear of counter, buffers and overrun
//   board_done    : one-cycle pulse after square SQUARES-1 is consumed
//   busy          : capture in flight, word pending or pieces left
//   overrun       : sticky, a word arrived with both buffers full
// Optional feature macro: BOARD_UNPACK_SKIP_EMPTY_EN - zero nibbles are
// consumed internally (one per cycle) instead of being presented.

module board_nibble_unpacker #(
    parameter int PIECE_W = 4,
    parameter int SQUARES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    board_nibble_unpacker_if.slave  bus,
    input  logic                    restart,
    output logic                    board_done,
    output logic                    busy,
    output logic                    overrun
);
    localparam int NPW  = 32 / PIECE_W;
    localparam int CW   = $clog2(NPW + 1);
    localparam logic [5:0]    LAST_SQ  = 6'(SQUARES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(NPW);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state;
    logic           cap_flag;
    logic [31:0]    sh;
    logic [CW-1:0]  nib_left;
    logic [31:0]    pend;
    logic           pend_v;
    logic [5:0]     sq_index;

    logic wr_hit;
    logic cur_zero;
    logic present;
    logic adv;
    logic last;

    assign wr_hit   = bus.chipselect & ~bus.write_n & (bus.address == 2'd0);
    assign cur_zero = (sh[PIECE_W-1:0] == '0);

`ifdef BOARD_UNPACK_SKIP_EMPTY_EN
    // Empty squares advance on their own; only occupied ones wait for sq_ready.
    assign present = (state == EMIT) & ~cur_zero;
    assign adv     = (state == EMIT) & (cur_zero | bus.sq_ready);
`else
    assign present = (state == EMIT);
    assign adv     = (state == EMIT) & bus.sq_ready;
`endif

    // The shift register frees up on the same edge its last nibble leaves,
    // so a waiting word (pending or just captured) loads without a bubble.
    assign last = adv & (nib_left == CW'(1));

    assign bus.sq_valid = present;
    assign bus.sq_index = sq_index;
    assign bus.sq_piece = sh[PIECE_W-1:0];
    assign busy         = cap_flag | pend_v | (nib_left != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cap_flag   <= 1'b0;
            sh         <= '0;
            nib_left   <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            sq_index   <= '0;
            overrun    <= 1'b0;
            board_done <= 1'b0;
        end else if (restart) begin
            state      <= IDLE;
            cap_flag   <= 1'b0;
            sh         <= '0;
            nib_left   <= '0;
            pend       <= '0;
            pend_v     <= 1'b0;
            sq_index   <= '0;
            overrun    <= 1'b0;
            board_done <= 1'b0;
        end else begin
            // pio_data is already updated by the PIO in the cycle after the write.
            cap_flag   <= wr_hit;
            board_done <= adv & (sq_index == LAST_SQ);

            if (adv) begin
                sq_index <= (sq_index == LAST_SQ) ? 6'd0 : sq_index + 6'd1;
            end

            if ((state == IDLE) || last) begin
                if (pend_v) begin
                    sh       <= pend;
                    nib_left <= FULL_CNT;
                    state    <= EMIT;
                    if (cap_flag) begin
                        pend <= bus.pio_data;
                    end else begin
                        pend_v <= 1'b0;
                    end
                end else if (cap_flag) begin
                    sh       <= bus.pio_data;
                    nib_left <= FULL_CNT;
                    state    <= EMIT;
                end else begin
                    sh       <= '0;
                    nib_left <= '0;
                    state    <= IDLE;
                end
            end else begin
                if (adv) begin
                    sh       <= sh >> PIECE_W;
                    nib_left <= nib_left - CW'(1);
                end
                if (cap_flag) begin
                    if (!pend_v) begin
                        pend   <= bus.pio_data;
                        pend_v <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_board_nibble_unpacker.sv
// tb/tb_board_nibble_unpacker.sv - directed self-checking bench for board_nibble_unpacker

module tb_board_nibble_unpacker;
    logic clk;
    logic reset_n;
    logic restart;
    logic board_done;
    logic busy;
    logic overrun;

    int errors = 0;
    int checks = 0;

    board_nibble_unpacker_if #(.PIECE_W(4)) bus ();

    board_nibble_unpacker #(.PIECE_W(4), .SQUARES(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .restart    (restart),
        .board_done (board_done),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; one write cycle, returns on the following negedge.
    task automatic do_write(input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd0;
        bus.pio_data   = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        restart        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.pio_data   = 32'h0;
        bus.sq_ready   = 1'b1;
        repeat (2) @(negedge clk);

        check_eq("rst_valid", {31'd0, bus.sq_valid}, 32'd0);
        check_eq("rst_index", {26'd0, bus.sq_index}, 32'd0);
        check_eq("rst_piece", {28'd0, bus.sq_piece}, 32'd0);
        check_eq("rst_done",  {31'd0, board_done}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        check_eq("rst_ovr",   {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // single word: capture cycle, then pieces 1..8 on squares 0..7
        do_write(32'h87654321);
        check_eq("sw_cap_valid", {31'd0, bus.sq_valid}, 32'd0);
        check_eq("sw_cap_busy",  {31'd0, busy}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_eq("sw_valid", {31'd0, bus.sq_valid}, 32'd1);
            check_eq("sw_piece", {28'd0, bus.sq_piece}, i + 1);
            check_eq("sw_index", {26'd0, bus.sq_index}, i);
            @(negedge clk);
        end
        check_eq("sw_end_valid", {31'd0, bus.sq_valid}, 32'd0);
        check_eq("sw_end_busy",  {31'd0, busy}, 32'd0);

        // backpressure: first piece held 5 cycles, index continues at 8
        bus.sq_ready = 1'b0;
        do_write(32'h87654321);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_valid", {31'd0, bus.sq_valid}, 32'd1);
            check_eq("bp_hold_piece", {28'd0, bus.sq_piece}, 32'd1);
            check_eq("bp_hold_index", {26'd0, bus.sq_index}, 32'd8);
            @(negedge clk);
        end
        bus.sq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("bp_piece", {28'd0, bus.sq_piece}, i + 1);
            check_eq("bp_index", {26'd0, bus.sq_index}, 8 + i);
            @(negedge clk);
        end
        check_eq("bp_end_valid", {31'd0, bus.sq_valid}, 32'd0);

        // full board: 9 words, one every 8 cycles; word k carries nibble k+1
        pulse_restart();
        check_eq("fb_restart_index", {26'd0, bus.sq_index}, 32'd0);
        for (int c = 0; c < 76; c++) begin
            if (c >= 2 && c < 74) begin
                check_eq("fb_valid", {31'd0, bus.sq_valid}, 32'd1);
                check_eq("fb_piece", {28'd0, bus.sq_piece}, ((c - 2) / 8) + 1);
                check_eq("fb_index", {26'd0, bus.sq_index}, (c - 2) % 64);
            end else begin
                check_eq("fb_idle_valid", {31'd0, bus.sq_valid}, 32'd0);
            end
            check_eq("fb_done", {31'd0, board_done}, (c == 66) ? 32'd1 : 32'd0);
            if ((c % 8 == 0) && (c < 72)) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'd0;
                bus.pio_data   = 32'h11111111 * ((c / 8) + 1);
            end else begin
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b1;
            end
            @(negedge clk);
        end

        // overrun: third word with sh and pend full is dropped
        pulse_restart();
        bus.sq_ready = 1'b0;
        do_write(32'h11111111);
        @(negedge clk);
        do_write(32'h22222222);
        @(negedge clk);
        check_eq("ov_before", {31'd0, overrun}, 32'd0);
        do_write(32'h33333333);
        @(negedge clk);
        check_eq("ov_set",   {31'd0, overrun}, 32'd1);
        check_eq("ov_piece", {28'd0, bus.sq_piece}, 32'd1);
        check_eq("ov_busy",  {31'd0, busy}, 32'd1);
        bus.sq_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("ov_valid", {31'd0, bus.sq_valid}, 32'd1);
            check_eq("ov_stream_piece", {28'd0, bus.sq_piece}, (i < 8) ? 32'd1 : 32'd2);
            check_eq("ov_stream_index", {26'd0, bus.sq_index}, i);
            @(negedge clk);
        end
        check_eq("ov_dropped_valid", {31'd0, bus.sq_valid}, 32'd0);
        check_eq("ov_sticky", {31'd0, overrun}, 32'd1);
        pulse_restart();
        check_eq("ov_clear", {31'd0, overrun}, 32'd0);
        check_eq("ov_clear_index", {26'd0, bus.sq_index}, 32'd0);

        // reset in the middle of a word
        do_write(32'h87654321);
        repeat (3) @(negedge clk);
        check_eq("mr_piece", {28'd0, bus.sq_piece}, 32'd3);
        check_eq("mr_index", {26'd0, bus.sq_index}, 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mr_valid", {31'd0, bus.sq_valid}, 32'd0);
        check_eq("mr_index0", {26'd0, bus.sq_index}, 32'd0);
        check_eq("mr_piece0", {28'd0, bus.sq_piece}, 32'd0);
        check_eq("mr_done",  {31'd0, board_done}, 32'd0);
        check_eq("mr_busy",  {31'd0, busy}, 32'd0);
        check_eq("mr_ovr",   {31'd0, overrun}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        do_write(32'h87654321);
        @(negedge clk);
        check_eq("mr_again_valid", {31'd0, bus.sq_valid}, 32'd1);
        check_eq("mr_again_piece", {28'd0, bus.sq_piece}, 32'd1);
        check_eq("mr_again_index", {26'd0, bus.sq_index}, 32'd0);
        repeat (8) @(negedge clk);
        check_eq("mr_again_end", {31'd0, bus.sq_valid}, 32'd0);

`ifdef BOARD_UNPACK_SKIP_EMPTY_EN
        // only 3@2 and 5@5 are presented from 0x00500300
        pulse_restart();
        do_write(32'h00500300);
        @(negedge clk);
        for (int s = 0; s < 9; s++) begin
            if (s == 2 || s == 5) begin
                check_eq("sk_valid", {31'd0, bus.sq_valid}, 32'd1);
                check_eq("sk_piece", {28'd0, bus.sq_piece}, (s == 2) ? 32'd3 : 32'd5);
                check_eq("sk_index", {26'd0, bus.sq_index}, s);
            end else begin
                check_eq("sk_hidden", {31'd0, bus.sq_valid}, 32'd0);
            end
            @(negedge clk);
        end
        check_eq("sk_index_end", {26'd0, bus.sq_index}, 32'd8);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
